axis_fifo_rr_arbiter: RTL and testbench
=======================================

# axis_fifo_rr_arbiter

Round-robin packet scheduler that sits directly upstream of the AXI-Stream `tready` demultiplexer and drives its `bus_sel` code. Watches the `tvalid` of up to ten source FIFOs and grants the shared output bus to one FIFO at a time. Each grant is held for a whole packet, until the `tlast` handshake, so packets from different FIFOs never interleave. Also flags over-length and stalled packets.

## Interface
- `NUM_CH`, 10: number of source FIFOs, 1..10; channel n is encoded on `bus_sel` as 128+n.
- `MAX_BEATS`, 1024: maximum beats per packet, 1..65535.
- `STALL_TIMEOUT`, 256: cycles a granted FIFO may hold `tvalid` low mid-packet, 1..65535.
- `clk`  in  1  sole clock. One clock domain; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_tvalid`  in  NUM_CH  per-FIFO `tvalid`; bit n belongs to FIFO n.
- `axis_in_tvalid`  in  1  `tvalid` of the muxed stream on the shared bus.
- `axis_in_tready`  in  1  `tready` from the downstream consumer; the same signal the demux fans out.
- `axis_in_tlast`  in  1  `tlast` of the muxed stream.
- `bus_sel`  out  8  registered select: 128+n while FIFO n is granted, 8'd0 when nothing is granted.
- `grant_active`  out  1  high while in BUSY.
- `pkt_done`  out  1  one-cycle pulse when a packet ends normally.
- `err_len`  out  1  one-cycle pulse when a packet is released by the length limit.
- `err_stall`  out  1  one-cycle pulse when a packet is released by the stall timeout.
- `pkt_count`  out  16  count of normally completed packets; wraps 0xFFFF to 0.

## Operation
- A beat is a cycle with `axis_in_tvalid` and `axis_in_tready` both high.
- The arbiter keeps a pointer `last` holding the most recently granted channel. Reset value is NUM_CH-1, so the first search starts at channel 0.
- IDLE:
  - `bus_sel`=0 and `grant_active`=0.
  - If any `fifo_tvalid` bit is high, select the first set bit found searching `last`+1, `last`+2, … with wrap at NUM_CH.
  - Next cycle: `bus_sel`=128+n, `grant_active`=1, state BUSY.
  - Beat counter and stall counter are cleared.
- BUSY, each beat:
  - The beat counter increments.
  - If `axis_in_tlast`=1: go to IDLE, set `last`=n, pulse `pkt_done`, increment `pkt_count`.
  - Else, if the beat counter reaches MAX_BEATS: go to IDLE, set `last`=n, pulse `err_len`.
- BUSY, stall tracking:
  - A cycle with `fifo_tvalid[n]`=0 increments the stall counter.
  - A cycle with `fifo_tvalid[n]`=1 clears it.
  - When the stall counter reaches STALL_TIMEOUT: go to IDLE, set `last`=n, pulse `err_stall`.
- Priority in a single cycle: `tlast` beat > length limit > stall timeout. Only one of `pkt_done`/`err_len`/`err_stall` pulses per cycle.
- After an error release, leftover beats of the aborted packet are not tracked; upstream flushes them.
- `fifo_tvalid` bits for channels ≥ NUM_CH are ignored.
- `bus_sel` never takes any value other than 0 or 128+n with n < NUM_CH.

## Timing
- Reset, asynchronous, takes effect immediately, including mid-packet:
  - `bus_sel`=0, `grant_active`=0, `pkt_done`=`err_len`=`err_stall`=0, `pkt_count`=0.
  - `last`=NUM_CH-1, state IDLE.
- Grant latency: a `fifo_tvalid` bit high in IDLE at edge t gives `bus_sel` valid after edge t+1.
- Release: an end-of-packet event at edge t gives `bus_sel`=0 after edge t+1.
- IDLE always lasts at least one cycle, so back-to-back packets have a one-cycle bus gap.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Pulses are exactly one cycle wide, aligned with the cycle in which `bus_sel` returns to 0.

## Test plan
- Reset mid-packet: grant channel 3, send 2 beats, assert `rst_n`=0 → `bus_sel`=0 within the same cycle; after release the first request on channel 3 is granted again, since search starts at 0.
- Round-robin: all 10 `fifo_tvalid` high, 1-beat packets each with `tlast` → `bus_sel` sequence 128,129,…,137,128 with one 0 cycle between grants; `pkt_count`=11.
- Packet hold: channel 2 granted, channel 5 requesting, 4-beat packet with `tready` toggling 1,0,1,0 → `bus_sel` stays 130 until the 4th beat with `tlast`, then 0, then 133.
- Length limit, MAX_BEATS=8: send 8 beats without `tlast` → `err_len` pulse; `pkt_count` unchanged; next grant goes to the next requester.
- Stall, STALL_TIMEOUT=4: granted `fifo_tvalid` low for 4 cycles → `err_stall` pulse; a `tlast` beat landing on the timeout cycle instead gives `pkt_done` only.
- `pkt_count` wrap: preload to 0xFFFF through a forced sequence, complete one packet → `pkt_count`=0.

Source files
------------

// File: rtl/axis_fifo_rr_arbiter_if.sv
// Shared-bus view of the round-robin packet scheduler: per-FIFO requests, muxed-stream handshake,
// bus select and status pulses. The master modport is the arbiter, the slave modport is its environment.
interface axis_fifo_rr_arbiter_if #(
  parameter int NUM_CH = 10
);
  logic [NUM_CH-1:0] fifo_tvalid;
  logic              axis_in_tvalid;
  logic              axis_in_tready;
  logic              axis_in_tlast;
  logic [7:0]        bus_sel;
  logic              grant_active;
  logic              pkt_done;
  logic              err_len;
  logic              err_stall;
  logic [15:0]       pkt_count;

  modport master (
    input  fifo_tvalid, axis_in_tvalid, axis_in_tready, axis_in_tlast,
    output bus_sel, grant_active, pkt_done, err_len, err_stall, pkt_count
  );

  modport slave (
    output fifo_tvalid, axis_in_tvalid, axis_in_tready, axis_in_tlast,
    input  bus_sel, grant_active, pkt_done, err_len, err_stall, pkt_count
  );
endinterface

// File: rtl/axis_fifo_rr_arbiter.sv
// Round-robin packet scheduler: grant 1 cycle after request, held until the tlast beat, length limit or stall timeout.
// Does not backpressure: beats are observed only when the muxed stream's tvalid and tready are both high.
module axis_fifo_rr_arbiter #(
  parameter int NUM_CH        = 10,
  parameter int MAX_BEATS     = 1024,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_fifo_rr_arbiter_if.master bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cur;
  logic [CW-1:0] last;
  logic [15:0]   beat_cnt;
  logic [15:0]   stall_cnt;
  logic [15:0]   pkt_cnt_q;
  logic [7:0]    sel_q;
  logic          grant_q;
  logic          done_q;
  logic          len_q;
  logic          stall_q;

  // Requests above `last` win over requests at or below it; the lowest index wins within each group.
  logic          hi_found;
  logic          lo_found;
  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;
  logic [CW-1:0] pick;
  logic          any_req;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.fifo_tvalid[i]) begin
        if (CW'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = CW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = CW'(i);
        end
      end
    end
    pick    = hi_found ? hi_idx : lo_idx;
    any_req = hi_found | lo_found;
  end

  logic beat;
  logic cur_vld;
  logic end_last;
  logic end_len;
  logic end_stall;
  logic release_pkt;

  assign beat        = bus.axis_in_tvalid & bus.axis_in_tready;
  assign cur_vld     = bus.fifo_tvalid[cur];
  assign end_last    = beat & bus.axis_in_tlast;
  assign end_len     = beat & (({1'b0, beat_cnt} + 17'd1) == 17'(MAX_BEATS));
  assign end_stall   = ~cur_vld & (({1'b0, stall_cnt} + 17'd1) == 17'(STALL_TIMEOUT));
  assign release_pkt = end_last | end_len | end_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= CW'(NUM_CH - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
      pkt_cnt_q <= '0;
      sel_q     <= '0;
      grant_q   <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      len_q   <= 1'b0;
      stall_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= BUSY;
            cur       <= pick;
            sel_q     <= 8'd128 + 8'(pick);
            grant_q   <= 1'b1;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        BUSY: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 16'd1;
          end
          stall_cnt <= cur_vld ? 16'd0 : stall_cnt + 16'd1;
          // Single-cycle priority: tlast beat, then length limit, then stall timeout.
          if (release_pkt) begin
            state   <= IDLE;
            sel_q   <= '0;
            grant_q <= 1'b0;
            last    <= cur;
            done_q  <= end_last;
            len_q   <= ~end_last & end_len;
            stall_q <= ~end_last & ~end_len & end_stall;
            if (end_last) begin
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_sel      = sel_q;
  assign bus.grant_active = grant_q;
  assign bus.pkt_done     = done_q;
  assign bus.err_len      = len_q;
  assign bus.err_stall    = stall_q;
  assign bus.pkt_count    = pkt_cnt_q;
endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Directed and randomized bench for axis_fifo_rr_arbiter against a packet-level reference model.
module tb_axis_fifo_rr_arbiter;
  localparam int NC   = 10;
  localparam int MAXB = 8;
  localparam int STO  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  axis_fifo_rr_arbiter_if #(.NUM_CH(NC)) bus ();

  axis_fifo_rr_arbiter #(
    .NUM_CH(NC), .MAX_BEATS(MAXB), .STALL_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: granted channel (-1 when idle) and expected registered outputs.
  int          m_gch;
  int          m_last;
  int          m_beats;
  int          m_stall;
  logic [7:0]  m_sel;
  logic        m_grant, m_done, m_len, m_stl;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gch = -1; m_last = NC - 1; m_beats = 0; m_stall = 0;
    m_sel = 8'd0; m_grant = 1'b0; m_done = 1'b0; m_len = 1'b0; m_stl = 1'b0;
    m_cnt = 16'd0;
  endtask

  task automatic model_step();
    bit beat;
    int c;
    m_done = 1'b0; m_len = 1'b0; m_stl = 1'b0;
    if (m_gch < 0) begin
      for (int k = 1; k <= NC; k++) begin
        c = (m_last + k) % NC;
        if (m_gch < 0 && bus.fifo_tvalid[c]) m_gch = c;
      end
      if (m_gch >= 0) begin
        m_beats = 0; m_stall = 0;
        m_sel = 8'(128 + m_gch); m_grant = 1'b1;
      end
    end else begin
      beat = bus.axis_in_tvalid && bus.axis_in_tready;
      if (beat) m_beats++;
      if (bus.fifo_tvalid[m_gch]) m_stall = 0; else m_stall++;
      if (beat && bus.axis_in_tlast) begin
        m_done = 1'b1; m_cnt = m_cnt + 16'd1;
      end else if (beat && m_beats == MAXB) m_len = 1'b1;
      else if (m_stall == STO) m_stl = 1'b1;
      if (m_done || m_len || m_stl) begin
        m_last = m_gch; m_gch = -1; m_sel = 8'd0; m_grant = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("bus_sel", 32'(bus.bus_sel), 32'(m_sel));
    check("grant_active", 32'(bus.grant_active), 32'(m_grant));
    check("pkt_done", 32'(bus.pkt_done), 32'(m_done));
    check("err_len", 32'(bus.err_len), 32'(m_len));
    check("err_stall", 32'(bus.err_stall), 32'(m_stl));
    check("pkt_count", 32'(bus.pkt_count), 32'(m_cnt));
  endtask

  task automatic set_in(input logic [NC-1:0] f, input logic v, input logic r, input logic l);
    bus.fifo_tvalid = f; bus.axis_in_tvalid = v; bus.axis_in_tready = r; bus.axis_in_tlast = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_in('0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("rst_bus_sel", 32'(bus.bus_sel), 32'd0);
    check("rst_grant", 32'(bus.grant_active), 32'd0);
    check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);

    // Reset mid-packet on channel 3, then re-grant of channel 3.
    set_in(NC'(1 << 3), 1'b1, 1'b1, 1'b0);
    tick();
    check("grant_ch3", 32'(bus.bus_sel), 32'd131);
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_sel", 32'(bus.bus_sel), 32'd0);
    check("async_rst_grant", 32'(bus.grant_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.axis_in_tlast = 1'b1;
    tick();
    check("regrant_ch3", 32'(bus.bus_sel), 32'd131);
    tick();
    check("ch3_done", 32'(bus.pkt_done), 32'd1);

    // Round-robin over all channels with single-beat packets.
    do_reset();
    set_in('1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 11; k++) begin
      tick();
      check("rr_sel", 32'(bus.bus_sel), 32'(128 + (k % NC)));
      tick();
      check("rr_gap", 32'(bus.bus_sel), 32'd0);
    end
    check("rr_pkt_count", 32'(bus.pkt_count), 32'd11);
    set_in('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Packet hold while another channel requests.
    do_reset();
    set_in(NC'(1 << 2), 1'b1, 1'b0, 1'b0);
    tick();
    check("hold_grant", 32'(bus.bus_sel), 32'd130);
    bus.fifo_tvalid = NC'((1 << 2) | (1 << 5));
    for (int j = 0; j < 7; j++) begin
      bus.axis_in_tready = (j % 2 == 0);
      bus.axis_in_tlast  = (j == 6);
      tick();
      check("hold_sel", 32'(bus.bus_sel), (j < 6) ? 32'd130 : 32'd0);
    end
    set_in(NC'((1 << 2) | (1 << 5)), 1'b1, 1'b0, 1'b0);
    tick();
    check("hold_next", 32'(bus.bus_sel), 32'd133);
    set_in(NC'(1 << 5), 1'b1, 1'b1, 1'b1);
    tick();
    set_in('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Length limit, then stall timeout, then tlast on the timeout cycle.
    do_reset();
    set_in(NC'((1 << 1) | (1 << 4)), 1'b1, 1'b1, 1'b0);
    tick();
    check("len_grant", 32'(bus.bus_sel), 32'd129);
    for (int b = 1; b <= MAXB; b++) tick();
    check("len_err", 32'(bus.err_len), 32'd1);
    check("len_count", 32'(bus.pkt_count), 32'd0);
    tick();
    check("len_next", 32'(bus.bus_sel), 32'd132);
    set_in(NC'(1 << 1), 1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= STO; s++) begin
      tick();
      check("stall_sel", 32'(bus.bus_sel), (s < STO) ? 32'd132 : 32'd0);
    end
    check("stall_err", 32'(bus.err_stall), 32'd1);
    tick();
    check("stall_next", 32'(bus.bus_sel), 32'd129);
    set_in('0, 1'b0, 1'b0, 1'b0);
    for (int s = 1; s < STO; s++) tick();
    set_in('0, 1'b1, 1'b1, 1'b1);
    tick();
    check("tlast_at_timeout_done", 32'(bus.pkt_done), 32'd1);
    check("tlast_at_timeout_stall", 32'(bus.err_stall), 32'd0);
    set_in('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Packet counter wrap from 0xFFFF.
    force dut.pkt_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    check("wrap_preload", 32'(bus.pkt_count), 32'hFFFF);
    set_in(NC'(1), 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("wrap_zero", 32'(bus.pkt_count), 32'd0);
    set_in('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.fifo_tvalid    = NC'($urandom_range(0, (1 << NC) - 1));
      bus.axis_in_tvalid = ($urandom_range(0, 3) != 0);
      bus.axis_in_tready = ($urandom_range(0, 3) != 0);
      bus.axis_in_tlast  = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
